tart_bank_scheduler: RTL and testbench

- Sequences correlator bank-swaps for the visibilities path.
- Counts valid correlator sample strobes and issues a one-cycle swap pulse when a block of (blocksize + 1) samples completes.
- Tracks the prefetch/readout lifecycle of the frozen bank (fetching, ready for SPI, read) and flags overruns.
- Sits between the acquisition/correlator front-end and the visibilities prefetch/SRAM unit; `switch_o` drives that unit's `switching` input.

---
 rtl/tart_sched_pkg.sv | 20 ++
 rtl/tart_readout_tracker.sv | 73 +++++++
 rtl/tart_bank_scheduler.sv | 112 +++++++++++
 tb/tb_tart_bank_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tart_sched_pkg
// Brief   : Shared tracker state encodings and default widths for the
//           TART bank scheduler and readout tracker.
// Revision: 1.0 - initial release
// ============================================================================
package tart_sched_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_bbits = 4;

    typedef enum logic [1:0] {
        TRK_EMPTY = 2'b00,
        TRK_FETCH = 2'b01,
        TRK_READY = 2'b10
    } trk_state_t;

endpackage
`default_nettype wire

// File: rtl/tart_readout_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tart_readout_tracker
// Brief   : Frozen-bank lifecycle (EMPTY/FETCH/READY) with sticky overrun.
//           HOLD_EN=1 grants a swap only when the bank has been read out.
// Revision: 1.0 - initial release
// ============================================================================
module tart_readout_tracker
    import tart_sched_pkg::*;
#(
    parameter bit HOLD_EN = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic swap_req_i,
    input  logic drop_i,
    input  logic prefetch_done_i,
    input  logic read_done_i,
    input  logic clear_i,
    output logic swap_o,
    output logic busy_o,
    output logic available_o,
    output logic overrun_o
);

    trk_state_t r_state;
    trk_state_t w_state_eff;
    trk_state_t w_state_next;
    logic       r_busy;
    logic       r_avail;
    logic       r_overrun;
    logic       w_overrun_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= TRK_EMPTY;
            r_busy    <= 1'b0;
            r_avail   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= (w_state_next == TRK_FETCH);
            r_avail   <= (w_state_next == TRK_READY);
            r_overrun <= w_overrun_next;
        end
    end

    // Completion events are applied before a coincident swap is considered.
    always_comb begin
        w_state_eff = r_state;
        case (r_state)
            TRK_FETCH: if (prefetch_done_i) w_state_eff = TRK_READY;
            TRK_READY: if (read_done_i)     w_state_eff = TRK_EMPTY;
            TRK_EMPTY: w_state_eff = TRK_EMPTY;
            default:   w_state_eff = TRK_EMPTY;
        endcase

        swap_o       = swap_req_i && (!HOLD_EN || (w_state_eff == TRK_EMPTY));
        w_state_next = swap_o ? TRK_FETCH : w_state_eff;

        w_overrun_next = r_overrun;
        if (clear_i)
            w_overrun_next = 1'b0;
        if ((swap_o && (w_state_eff != TRK_EMPTY)) || drop_i)
            w_overrun_next = 1'b1;
    end

    assign busy_o      = r_busy;
    assign available_o = r_avail;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/tart_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tart_bank_scheduler
// Brief   : Counts correlator strobes, pulses switch_o every blocksize+1
//           samples and tracks readout of the frozen bank.
//           Define TART_BANK_HOLD_EN to defer swaps until the bank is read.
// Revision: 1.0 - initial release
// ============================================================================
module tart_bank_scheduler
    import tart_sched_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int BBITS = c_default_bbits,
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] blocksize_i,
    input  logic             prefetch_done_i,
    input  logic             read_done_i,
    input  logic             clear_i,
    output logic             switch_o,
    output logic [BBITS-1:0] bank_o,
    output logic [WIDTH-1:0] count_o,
    output logic             available_o,
    output logic             busy_o,
    output logic             overrun_o
);

    // DELAY is a simulation-only setting; registered outputs carry no modelled delay here.
    if (DELAY < 0) begin : g_delay_check
        $error("tart_bank_scheduler: DELAY must be non-negative");
    end

    logic [WIDTH-1:0] r_count;
    logic [BBITS-1:0] r_bank;
    logic             r_switch;
    logic             w_accept;
    logic             w_due;
    logic             w_swap_req;
    logic             w_swap;
    logic             w_drop;

`ifdef TART_BANK_HOLD_EN
    localparam bit c_hold_en = 1'b1;
    logic r_pending;

    // A completed block waits here, holding off strobes, until the bank is free.
    assign w_accept   = enable_i && strobe_i && !r_pending;
    assign w_due      = w_accept && (r_count >= blocksize_i);
    assign w_swap_req = enable_i && (w_due || r_pending);
    assign w_drop     = w_due && !w_swap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_pending <= 1'b0;
        else if (!enable_i || w_swap)
            r_pending <= 1'b0;
        else if (w_due)
            r_pending <= 1'b1;
    end
`else
    localparam bit c_hold_en = 1'b0;

    assign w_accept   = enable_i && strobe_i;
    assign w_due      = w_accept && (r_count >= blocksize_i);
    assign w_swap_req = w_due;
    assign w_drop     = 1'b0;
`endif

    tart_readout_tracker #(
        .HOLD_EN (c_hold_en)
    ) u_tracker (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .swap_req_i      (w_swap_req),
        .drop_i          (w_drop),
        .prefetch_done_i (prefetch_done_i),
        .read_done_i     (read_done_i),
        .clear_i         (clear_i),
        .swap_o          (w_swap),
        .busy_o          (busy_o),
        .available_o     (available_o),
        .overrun_o       (overrun_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_bank   <= '0;
            r_switch <= 1'b0;
        end else begin
            r_switch <= w_swap;
            if (w_swap)
                r_bank <= r_bank + BBITS'(1);
            if (!enable_i || w_swap)
                r_count <= '0;
            else if (w_due)
                r_count <= blocksize_i;
            else if (w_accept)
                r_count <= r_count + WIDTH'(1);
        end
    end

    assign switch_o = r_switch;
    assign bank_o   = r_bank;
    assign count_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_tart_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tart_bank_scheduler
// Brief   : Directed and random checks of tart_bank_scheduler against a
//           cycle-level reference of the block/readout rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tart_bank_scheduler;

    localparam int WIDTH = 32;
    localparam int BBITS = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic             strobe_i;
    logic [WIDTH-1:0] blocksize_i;
    logic             prefetch_done_i;
    logic             read_done_i;
    logic             clear_i;
    logic             switch_o;
    logic [BBITS-1:0] bank_o;
    logic [WIDTH-1:0] count_o;
    logic             available_o;
    logic             busy_o;
    logic             overrun_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: sample count, bank number and whether the frozen bank is
    // still being fetched or is waiting to be read.
    int m_count;
    int m_bank;
    bit m_switch;
    bit m_fetching;
    bit m_ready;
    bit m_ovr;

    always #5 clk_i = ~clk_i;

    tart_bank_scheduler #(
        .WIDTH (WIDTH),
        .BBITS (BBITS),
        .DELAY (3)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .strobe_i        (strobe_i),
        .blocksize_i     (blocksize_i),
        .prefetch_done_i (prefetch_done_i),
        .read_done_i     (read_done_i),
        .clear_i         (clear_i),
        .switch_o        (switch_o),
        .bank_o          (bank_o),
        .count_o         (count_o),
        .available_o     (available_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_bank = 0; m_switch = 0;
        m_fetching = 0; m_ready = 0; m_ovr = 0;
    endtask

    task automatic drive(input logic en, input logic stb, input int bs,
                         input logic pd, input logic rd, input logic clr);
        enable_i        = en;
        strobe_i        = stb;
        blocksize_i     = bs;
        prefetch_done_i = pd;
        read_done_i     = rd;
        clear_i         = clr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".switch"},  switch_o,    0);
        check({tag, ".bank"},    bank_o,      0);
        check({tag, ".count"},   count_o,     0);
        check({tag, ".busy"},    busy_o,      0);
        check({tag, ".avail"},   available_o, 0);
        check({tag, ".overrun"}, overrun_o,   0);
    endtask

`ifndef TART_BANK_HOLD_EN
    task automatic step(input logic en, input logic stb, input int bs,
                        input logic pd, input logic rd, input logic clr);
        bit swap;
        drive(en, stb, bs, pd, rd, clr);
        swap = en && stb && (m_count >= bs);
        if (!en)
            m_count = 0;
        else if (stb)
            m_count = swap ? 0 : m_count + 1;
        if (swap)
            m_bank = (m_bank + 1) % (1 << BBITS);
        m_switch = swap;
        if (m_fetching && pd) begin
            m_fetching = 0;
            m_ready    = 1;
        end else if (m_ready && rd) begin
            m_ready = 0;
        end
        if (clr)
            m_ovr = 0;
        if (swap) begin
            if (m_fetching || m_ready)
                m_ovr = 1;
            m_fetching = 1;
            m_ready    = 0;
        end
        check("switch",  switch_o,    m_switch);
        check("bank",    bank_o,      m_bank);
        check("count",   count_o,     m_count);
        check("busy",    busy_o,      m_fetching);
        check("avail",   available_o, m_ready);
        check("overrun", overrun_o,   m_ovr);
    endtask
`endif

    initial begin
        int bs;
        rst_ni = 1'b0;
        enable_i = 0; strobe_i = 0; blocksize_i = '0;
        prefetch_done_i = 0; read_done_i = 0; clear_i = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        rst_ni = 1'b1;

`ifdef TART_BANK_HOLD_EN
        drive(1, 1, 1, 0, 0, 0);
        check("hold.count1", count_o, 1);
        drive(1, 1, 1, 0, 0, 0);
        check("hold.sw1", switch_o, 1);
        check("hold.busy", busy_o, 1);
        drive(1, 0, 1, 1, 0, 0);
        check("hold.avail", available_o, 1);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        check("hold.sat", count_o, 1);
        check("hold.ovr", overrun_o, 1);
        check("hold.nosw", switch_o, 0);
        drive(1, 1, 1, 0, 0, 0);
        check("hold.sat2", count_o, 1);
        check("hold.bank1", bank_o, 1);
        drive(1, 0, 1, 0, 1, 0);
        check("hold.sw2", switch_o, 1);
        check("hold.bank2", bank_o, 2);
        check("hold.count0", count_o, 0);
        check("hold.busy2", busy_o, 1);
`else
        // Back-to-back blocks of four samples.
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 3, 0, 0, 0);
            if (i == 4) begin
                check("blk.first_switch", switch_o, 1);
                check("blk.first_bank", bank_o, 1);
            end
        end
        check("blk.bank3", bank_o, 3);

        // Full fetch/read lifecycle with a long prefetch.
        step(1, 0, 3, 0, 0, 1);
        step(1, 0, 3, 1, 0, 0);
        step(1, 0, 3, 0, 1, 0);
        repeat (4) step(1, 1, 3, 0, 0, 0);
        repeat (10) step(1, 0, 3, 0, 0, 0);
        check("life.busy_held", busy_o, 1);
        step(1, 0, 3, 1, 0, 0);
        check("life.avail", available_o, 1);
        repeat (3) step(1, 0, 3, 0, 0, 0);
        step(1, 0, 3, 0, 1, 0);
        check("life.empty_avail", available_o, 0);
        check("life.no_overrun", overrun_o, 0);

        // Unread bank overrun, then clear.
        repeat (4) step(1, 1, 1, 0, 0, 0);
        check("ovr.set", overrun_o, 1);
        step(1, 0, 1, 0, 0, 1);
        check("ovr.clear", overrun_o, 0);

        // Read completion coincident with a swap.
        step(1, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        check("coinc.switch", switch_o, 1);
        check("coinc.busy", busy_o, 1);
        check("coinc.overrun", overrun_o, 0);

        // Enable drop mid-block restarts the block.
        repeat (2) step(1, 1, 3, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        check("en.count_clr", count_o, 0);
        repeat (3) step(1, 1, 3, 0, 0, 0);
        check("en.no_early_sw", switch_o, 0);
        step(1, 1, 3, 0, 0, 0);
        check("en.full_block_sw", switch_o, 1);

        // Asynchronous reset mid-block and mid-fetch.
        repeat (2) step(1, 1, 3, 0, 0, 0);
        rst_ni = 1'b0;
        #2;
        check_zero("midreset");
        model_reset();
        rst_ni = 1'b1;

        // Random traffic against the reference.
        bs = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                bs = $urandom_range(0, 4);
            step($urandom_range(0, 15) != 0, $urandom_range(0, 9) < 7, bs,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 15) == 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
